iob_vga_timing: RTL and testbench
=================================

// Module: iob_vga_timing
// PURPOSE
// - VGA raster timing generator and pixel output stage. Feeds pixel_x/pixel_y to the PMEM colour lookup and takes its 12-bit rgb back.
// - Drives the board VGA pins (hs, vs, 4:4:4 rgb) with all outputs registered and mutually aligned.
// - Default mode: 640x480@60, 25 MHz pixel rate derived from the 100 MHz system clock by clock enable (no second clock).
// PARAMETERS
// - CLK_DIV   4    system clocks per pixel (>=1); pix_tick every CLK_DIV cycles
// - H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48    horizontal timing in pixels (H_TOT=800)
// - V_VIS 480, V_FP 10, V_SYNC 2,  V_BP 33    vertical timing in lines (V_TOT=525)
// - SYNC_POL  0    active level of hs/vs (0 = active-low, VGA 640x480 standard)
// PORTS
// - clk          in   1   system clock
// - rst_n        in   1   reset, asynchronous assert, active-low
// - en           in   1   run enable; 0 = synchronous clear to reset state
// - pixel_x      out  10  current horizontal count h_cnt (to PMEM)
// - pixel_y      out  10  current vertical count v_cnt (to PMEM)
// - rgb_in       in   12  colour from PMEM for (pixel_x,pixel_y); combinational, same cycle; [11:8]=R [7:4]=G [3:0]=B
// - vga_hs       out  1   horizontal sync
// - vga_vs       out  1   vertical sync
// - vga_r/g/b    out  4   each colour channel, 0 during blanking
// - vga_de       out  1   active-video flag aligned with vga_r/g/b
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low.
// - Reset / en=0: div_cnt=0, h_cnt=0, v_cnt=0, vga_hs=vga_vs=!SYNC_POL, vga_r/g/b=0, vga_de=0. en=0 mid-frame = same clear; restart on en=1 at (0,0).
// - Prescaler: div_cnt 0..CLK_DIV-1, pix_tick when div_cnt==CLK_DIV-1; CLK_DIV=1 -> tick every cycle.
// - On pix_tick: h_cnt wraps H_TOT-1 -> 0; on that wrap v_cnt increments, wraps V_TOT-1 -> 0 (simultaneous wrap at (799,524) -> (0,0)).
// - pixel_x/pixel_y are the counter registers directly; valid for the whole pixel period (including blanking).
// - Output regs load only on pix_tick, from pre-increment counts: de=(h<H_VIS)&&(v<V_VIS); hs active iff H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC; vs active iff V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC; rgb = de ? rgb_in : 0.
// - Latency: pin outputs lag pixel_x/y by exactly one pixel period (+1 clk); hs, vs, de, rgb always same alignment.
// - Counters 10 bits; parameters must give H_TOT, V_TOT <= 1024 (elaboration-time $error otherwise).
// CONFIGURATION
// - Macro IOB_VGA_FRAME_CNT_EN defined: extra ports frame_start out 1 (one-clk pulse on the pix_tick where (h,v) wraps to (0,0)) and frame_cnt out 16 (increments on that tick, wraps 0xFFFF->0, cleared by reset/en=0).
// - Undefined: ports absent, no extra logic; all other behaviour identical.
// STRUCTURE
// - Shared header iob_vga_defs.vh: default timing localparams, H_TOT/V_TOT derivation, counter width 10, rgb field slices.
// - Sub-module iob_vga_axis_cnt (x2: H and V): wrapping counter with inc/clear inputs, wrap output, registered sync/visible window decode.
// - Top: prescaler, chained H/V instances, output register stage, optional frame counter.
// TESTING
// - Reset: hold rst_n=0 mid-run -> all outputs at reset values immediately (async); release -> pixel_x increments every 4 clks from 0.
// - H timing: CLK_DIV=4 -> vga_hs low for 96*4=384 clks, period 800*4=3200 clks, first fall 656 pixels after the tick where pixel_x=0.
// - V timing: vga_vs low for 2 lines (6400 clks), frame period 525*3200=1,680,000 clks; de high 640 px x 480 lines per frame.
// - Alignment: rgb_in = {2'b0,pixel_x} -> vga_r/g/b equals the value of pixel_x one pixel earlier while de=1; 0 whenever de=0 (e.g. pixel_x=700 gives rgb 0).
// - en drop at (320,240) -> next clk counters (0,0), rgb 0, syncs inactive; en=1 -> fresh frame, first hs fall 656 pixels later.
// - IOB_VGA_FRAME_CNT_EN: run 3 frames -> 3 frame_start pulses 1,680,000 clks apart, frame_cnt=3; CLK_DIV=1 run checks 1-clk pixel rate.

Source files
------------

// File: rtl/iob_vga_timing_pkg.sv
// iob_vga_timing_pkg: shared defaults, widths, rgb layout and window helper for the VGA timing block
package iob_vga_timing_pkg;
  localparam int CW        = 10;
  localparam int CLK_DIV_D = 4;
  localparam int H_VIS_D   = 640;
  localparam int H_FP_D    = 16;
  localparam int H_SYNC_D  = 96;
  localparam int H_BP_D    = 48;
  localparam int V_VIS_D   = 480;
  localparam int V_FP_D    = 10;
  localparam int V_SYNC_D  = 2;
  localparam int V_BP_D    = 33;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;
  function automatic logic in_win(input int v, input int lo, input int hi);
    return v >= lo && v < hi;
  endfunction
endpackage

// File: rtl/iob_vga_axis_cnt.sv
// iob_vga_axis_cnt: one raster axis - wrapping counter, visible decode, registered sync pin
//   clk, rst_n  clock, async active-low reset
//   clr         synchronous clear to reset state
//   inc         advance the count (wraps TOT-1 -> 0)
//   ld          load the sync register from the current (pre-increment) count
//   cnt         current count
//   wrap        inc while at TOT-1
//   vis         count is inside the visible window
//   sync        registered sync level, SYNC_POL while in [S_LO, S_HI)
module iob_vga_axis_cnt
  import iob_vga_timing_pkg::*;
#(
  parameter int TOT      = 800,
  parameter int VIS      = 640,
  parameter int S_LO     = 656,
  parameter int S_HI     = 752,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic          ld,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          vis,
  output logic          sync
);
  assign wrap = inc && cnt == CW'(TOT - 1);
  assign vis  = in_win(int'(cnt), 0, VIS);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sync <= !SYNC_POL;
    end else if (clr) begin
      cnt  <= '0;
      sync <= !SYNC_POL;
    end else begin
      if (inc) cnt <= wrap ? '0 : cnt + CW'(1);
      if (ld) sync <= in_win(int'(cnt), S_LO, S_HI) ? SYNC_POL : !SYNC_POL;
    end
  end
endmodule

// File: rtl/iob_vga_timing.sv
// iob_vga_timing: VGA raster timing generator and registered pixel output stage
//   clk, rst_n      system clock, async active-low reset
//   en              run enable, 0 clears everything to the reset state
//   pixel_x/y       live H/V counts sent to the colour lookup
//   rgb_in          colour for (pixel_x, pixel_y), same cycle, [11:8]=R [7:4]=G [3:0]=B
//   vga_hs/vs       sync pins, active level SYNC_POL
//   vga_r/g/b, de   colour pins (0 in blanking) and active-video flag
//   frame_start,    with IOB_VGA_FRAME_CNT_EN defined: pulse when the raster
//   frame_cnt       wraps to (0,0) and a 16-bit count of those wraps
// Pins lag pixel_x/y by one pixel period: they load on pix_tick from the
// count that is about to be left behind.
module iob_vga_timing
  import iob_vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_D,
  parameter int H_VIS    = H_VIS_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_VIS    = V_VIS_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  input  logic [11:0]   rgb_in,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          vga_de
`ifdef IOB_VGA_FRAME_CNT_EN
  ,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
`endif
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW    = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  if (H_TOT > 1024 || V_TOT > 1024 || CLK_DIV < 1) begin : g_bad_cfg
    $error("iob_vga_timing: H_TOT/V_TOT must be <= 1024 and CLK_DIV >= 1");
  end
  logic [DW-1:0] div_cnt;
  logic          pix_tick, h_wrap, h_vis, v_vis, de_nxt;
  rgb_t          rgb_q;
  assign pix_tick = div_cnt == DW'(CLK_DIV - 1);
  assign de_nxt   = h_vis && v_vis;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else div_cnt <= (!en || pix_tick) ? '0 : div_cnt + DW'(1);
  end
  iob_vga_axis_cnt #(
    .TOT(H_TOT), .VIS(H_VIS), .S_LO(H_VIS + H_FP), .S_HI(H_VIS + H_FP + H_SYNC), .SYNC_POL(SYNC_POL)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .clr(!en), .inc(pix_tick), .ld(pix_tick),
    .cnt(pixel_x), .wrap(h_wrap), .vis(h_vis), .sync(vga_hs)
  );
`ifdef IOB_VGA_FRAME_CNT_EN
  logic v_wrap;
`endif
  iob_vga_axis_cnt #(
    .TOT(V_TOT), .VIS(V_VIS), .S_LO(V_VIS + V_FP), .S_HI(V_VIS + V_FP + V_SYNC), .SYNC_POL(SYNC_POL)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .clr(!en), .inc(h_wrap), .ld(pix_tick),
`ifdef IOB_VGA_FRAME_CNT_EN
    .wrap(v_wrap),
`else
    .wrap(),
`endif
    .cnt(pixel_y), .vis(v_vis), .sync(vga_vs)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_de <= 1'b0;
      rgb_q  <= '0;
    end else if (!en) begin
      vga_de <= 1'b0;
      rgb_q  <= '0;
    end else if (pix_tick) begin
      vga_de <= de_nxt;
      rgb_q  <= de_nxt ? rgb_t'(rgb_in) : '0;
    end
  end
  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;
`ifdef IOB_VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (!en) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= v_wrap;
      if (v_wrap) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_iob_vga_timing.sv
// tb_iob_vga_timing: directed checks of raster timing, alignment, en clear, reset and frame counter
module tb_iob_vga_timing;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  // small raster: H_TOT=16 (hs window 10..12), V_TOT=9 (vs window 5..6)
  logic [9:0] px, py, px1, py1, pxd, pyd;
  logic hs, vs, de, hs1, vs1, de1, hsd, vsd, ded;
  logic [3:0] r, g, b, r1, g1, b1, rd, gd, bd;
  logic [11:0] rgb, rgb1, rgbd;
  assign rgb  = {2'b0, px};
  assign rgb1 = {2'b0, px1};
  assign rgbd = 12'hABC;
`ifdef IOB_VGA_FRAME_CNT_EN
  logic fs, fs1, fsd;
  logic [15:0] fc, fc1, fcd;
`endif
  iob_vga_timing #(
    .CLK_DIV(4), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_x(px), .pixel_y(py), .rgb_in(rgb),
    .vga_hs(hs), .vga_vs(vs), .vga_r(r), .vga_g(g), .vga_b(b), .vga_de(de)
`ifdef IOB_VGA_FRAME_CNT_EN
    , .frame_start(fs), .frame_cnt(fc)
`endif
  );
  iob_vga_timing #(
    .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_x(px1), .pixel_y(py1), .rgb_in(rgb1),
    .vga_hs(hs1), .vga_vs(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_de(de1)
`ifdef IOB_VGA_FRAME_CNT_EN
    , .frame_start(fs1), .frame_cnt(fc1)
`endif
  );
  iob_vga_timing dutd (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_x(pxd), .pixel_y(pyd), .rgb_in(rgbd),
    .vga_hs(hsd), .vga_vs(vsd), .vga_r(rd), .vga_g(gd), .vga_b(bd), .vga_de(ded)
`ifdef IOB_VGA_FRAME_CNT_EN
    , .frame_start(fsd), .frame_cnt(fcd)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [34:0] act;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (px !== 10'd0 || de !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: px=%0d de=%b required px=0 de=0", px, de);
    end
    @(posedge clk);
    #1;
    total++;
    if (px !== 10'd1) begin
      bad++;
      $display("FAIL reset_first_tick: px=%0d required 1", px);
    end
    repeat (44) @(posedge clk);
    #1;
    total++;
    if (px !== 10'd12) begin
      bad++;
      $display("FAIL reset_run: px=%0d required 12", px);
    end
    #2;
    rst_n = 1'b0;
    #1;
    act = {px, py, hs, vs, de, r, g, b};
    total++;
    if (act !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'd0}) begin
      bad++;
      $display("FAIL reset_async: got %h required %h", act, {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'd0});
    end
  endtask

  task automatic test_raster();
    logic [34:0] act, exp;
    int p, hp, vp;
    logic e_de;
    do_reset();
    for (int m = 1; m <= 150; m++) begin
      repeat (4) @(posedge clk);
      #1;
      p = m - 1;
      hp = p % 16;
      vp = (p / 16) % 9;
      e_de = hp < 8 && vp < 4;
      exp = {10'(m % 16), 10'((m / 16) % 9), !(hp >= 10 && hp < 13), !(vp >= 5 && vp < 7),
             e_de, e_de ? 12'(hp) : 12'd0};
      act = {px, py, hs, vs, de, r, g, b};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL raster m=%0d: got %h required %h", m, act, exp);
      end
    end
  endtask

  task automatic test_en_drop();
    logic [34:0] act;
    int n;
    do_reset();
    repeat (4 * 37 + 1) @(posedge clk);
    #1;
    total++;
    if (px !== 10'd5 || py !== 10'd2) begin
      bad++;
      $display("FAIL en_pos: got (%0d,%0d) required (5,2)", px, py);
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    act = {px, py, hs, vs, de, r, g, b};
    total++;
    if (act !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'd0}) begin
      bad++;
      $display("FAIL en_clear: got %h required %h", act, {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'd0});
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (px !== 10'd0 || hs !== 1'b1) begin
      bad++;
      $display("FAIL en_hold: px=%0d hs=%b required px=0 hs=1", px, hs);
    end
    @(negedge clk);
    en = 1'b1;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (hs === 1'b0) begin
        n = i;
        break;
      end
    end
    total++;
    if (n != 44) begin
      bad++;
      $display("FAIL en_restart_hs: first fall at clk %0d required 44", n);
    end
  endtask

  task automatic test_default_h();
    int fall1, rise1, fall2, de_cnt;
    logic hs_prev, vs_bad;
    logic [11:0] rgb_at_100, rgb_at_3000;
    fall1 = 0; rise1 = 0; fall2 = 0; de_cnt = 0; vs_bad = 1'b0;
    rgb_at_100 = 12'hFFF; rgb_at_3000 = 12'hFFF;
    do_reset();
    hs_prev = 1'b1;
    for (int k = 1; k <= 6000; k++) begin
      @(posedge clk);
      #1;
      if (k <= 3200 && ded === 1'b1) de_cnt++;
      if (vsd !== 1'b1) vs_bad = 1'b1;
      if (k == 100) rgb_at_100 = {rd, gd, bd};
      if (k == 3000) rgb_at_3000 = {rd, gd, bd};
      if (hs_prev === 1'b1 && hsd === 1'b0) begin
        if (fall1 == 0) fall1 = k;
        else if (fall2 == 0) fall2 = k;
      end
      if (hs_prev === 1'b0 && hsd === 1'b1 && rise1 == 0) rise1 = k;
      hs_prev = hsd;
    end
    total++;
    if (fall1 != 2628) begin
      bad++;
      $display("FAIL def_first_fall: clk %0d required 2628", fall1);
    end
    total++;
    if (rise1 - fall1 != 384) begin
      bad++;
      $display("FAIL def_hs_width: %0d clks required 384", rise1 - fall1);
    end
    total++;
    if (fall2 - fall1 != 3200) begin
      bad++;
      $display("FAIL def_hs_period: %0d clks required 3200", fall2 - fall1);
    end
    total++;
    if (de_cnt != 2560) begin
      bad++;
      $display("FAIL def_de_line: %0d clks required 2560", de_cnt);
    end
    total++;
    if (rgb_at_100 !== 12'hABC || rgb_at_3000 !== 12'h000) begin
      bad++;
      $display("FAIL def_rgb: vis %h blank %h required abc 000", rgb_at_100, rgb_at_3000);
    end
    total++;
    if (vs_bad !== 1'b0) begin
      bad++;
      $display("FAIL def_vs_idle: vs left inactive level got %b required 0", vs_bad);
    end
  endtask

  task automatic test_clk_div1();
    int n;
    do_reset();
    @(posedge clk);
    #1;
    total++;
    if (px1 !== 10'd1 || de1 !== 1'b1 || {r1, g1, b1} !== 12'd0) begin
      bad++;
      $display("FAIL div1_first: px=%0d de=%b rgb=%h required 1 1 000", px1, de1, {r1, g1, b1});
    end
    repeat (15) @(posedge clk);
    #1;
    total++;
    if (px1 !== 10'd0 || py1 !== 10'd1) begin
      bad++;
      $display("FAIL div1_wrap: got (%0d,%0d) required (0,1)", px1, py1);
    end
    do_reset();
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (hs1 === 1'b0) begin
        n = i;
        break;
      end
    end
    total++;
    if (n != 11) begin
      bad++;
      $display("FAIL div1_hs_fall: clk %0d required 11", n);
    end
  endtask

`ifdef IOB_VGA_FRAME_CNT_EN
  task automatic test_frame();
    int pos[3];
    int np;
    np = 0;
    pos[0] = 0; pos[1] = 0; pos[2] = 0;
    do_reset();
    for (int k = 1; k <= 1800; k++) begin
      @(posedge clk);
      #1;
      if (fs === 1'b1) begin
        if (np < 3) pos[np] = k;
        np++;
      end
    end
    total++;
    if (np != 3 || pos[0] != 576 || pos[1] != 1152 || pos[2] != 1728) begin
      bad++;
      $display("FAIL frame_pulses: n=%0d at %0d %0d %0d required 3 at 576 1152 1728", np, pos[0], pos[1], pos[2]);
    end
    total++;
    if (fc !== 16'd3) begin
      bad++;
      $display("FAIL frame_cnt: %0d required 3", fc);
    end
    total++;
    if (fc1 !== 16'd12) begin
      bad++;
      $display("FAIL frame_cnt_div1: %0d required 12", fc1);
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (fc !== 16'd0 || fs !== 1'b0) begin
      bad++;
      $display("FAIL frame_clear: cnt=%0d fs=%b required 0 0", fc, fs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_raster();
    test_en_drop();
    test_clk_div1();
    test_default_h();
`ifdef IOB_VGA_FRAME_CNT_EN
    test_frame();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
